// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: multi-channel programmable pulse stretcher emitting MSB-first parallel words
// Ports: clk, rstb (async active-low); i_en global enable/abort; i_pulse per-channel trigger;
// i_len per-channel length in UIs; i_retrig per-channel reload mode; o_pulse per-channel word;
// o_busy word nonzero; o_done last-word strobe; o_drop ignored-edge strobe.
module pulse_gen_mc #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         i_en,
    input  logic [NUM_CH-1:0]            i_pulse,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  i_len,
    input  logic [NUM_CH-1:0]            i_retrig,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_pulse,
    output logic [NUM_CH-1:0]            o_busy,
    output logic [NUM_CH-1:0]            o_done,
    output logic [NUM_CH-1:0]            o_drop
);
    typedef enum logic {IDLE, ACTIVE} state_e;
    localparam logic [LEN_WIDTH-1:0] DW_L = LEN_WIDTH'(DATA_WIDTH);
    logic [NUM_CH-1:0] pulse_q;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) pulse_q <= '0;
        else       pulse_q <= i_pulse;
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e                 state_q, state_d;
        logic [LEN_WIDTH-1:0]   rem_q, rem_d, len, load_rem;
        logic [DATA_WIDTH-1:0]  word_q, word_d;
        logic                   busy_q, done_q, drop_q, drop_d, done_d;
        logic                   re, act, load, run, full;
        always_comb begin
            len      = i_len[c*LEN_WIDTH +: LEN_WIDTH];
            re       = i_pulse[c] & ~pulse_q[c];
            act      = state_q == ACTIVE;
            load     = i_en & re & (len != '0) & (~act | i_retrig[c]);
            drop_d   = i_en & re & ((len == '0) | (act & ~i_retrig[c]));
            run      = load | (i_en & act);
            load_rem = load ? len : rem_q;
            full     = load_rem >= DW_L;
            // Fewer than a word left: load_rem ones packed at the MSB end
            word_d   = !run ? '0 : full ? '1 : ~({DATA_WIDTH{1'b1}} >> load_rem);
            rem_d    = (run & full) ? load_rem - DW_L : '0;
            state_d  = (run && rem_d != '0) ? ACTIVE : IDLE;
            done_d   = run & (rem_d == '0);
        end
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                state_q <= IDLE;
                rem_q   <= '0;
                word_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                word_q  <= word_d;
                busy_q  <= run;
                done_q  <= done_d;
                drop_q  <= drop_d;
            end
        end
        assign o_pulse[c*DATA_WIDTH +: DATA_WIDTH] = word_q;
        assign o_busy[c] = busy_q;
        assign o_done[c] = done_q;
        assign o_drop[c] = drop_q;
    end
endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb_pulse_gen_mc: table-driven scoreboard bench for pulse_gen_mc
module tb_pulse_gen_mc;
    localparam int DW = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    logic         clk = 1'b0, rstb = 1'b0, i_en = 1'b0;
    logic [3:0]   i_pulse = '0, i_retrig = '0;
    logic [63:0]  i_len = '0;
    logic [255:0] o_pulse;
    logic [3:0]   o_busy, o_done, o_drop;
    typedef struct {int ch; logic [63:0] word; logic busy; logic done; logic drop;} exp_t;
    typedef struct {logic en; logic [3:0] p; logic [15:0] len; logic [3:0] rt; int ch;
                    logic [63:0] word; logic busy; logic done; logic drop;} vec_t;
    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0, errors = 0;
    string tag = "";
    always #5 clk = ~clk;
    pulse_gen_mc #(.NUM_CH(4), .DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
        .clk(clk), .rstb(rstb), .i_en(i_en), .i_pulse(i_pulse), .i_len(i_len),
        .i_retrig(i_retrig), .o_pulse(o_pulse), .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop)
    );
    task automatic check(input string name, input logic [267:0] act, input logic [267:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic apply(input logic en, input logic [3:0] p, input logic [63:0] lv, input logic [3:0] rt);
        @(negedge clk);
        i_en = en; i_pulse = p; i_len = lv; i_retrig = rt;
    endtask
    task automatic push(input int ch, input logic [63:0] w, input logic b, input logic d, input logic r);
        sb.push_back('{ch, w, b, d, r});
    endtask
    task automatic settle();
        exp_t e;
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s ch%0d {word,busy,done,drop}", tag, e.ch),
                  268'({o_pulse[e.ch*DW +: DW], o_busy[e.ch], o_done[e.ch], o_drop[e.ch]}),
                  268'({e.word, e.busy, e.done, e.drop}));
        end
    endtask
    initial begin
        // single pulses: len 100, 64, 1
        tbl.push_back('{1'b1, 4'h1, 16'd100, 4'h0, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd100, 4'h0, 0, 64'hFFFF_FFFF_F000_0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd100, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 16'd64, 4'h0, 1, ONES, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd64, 4'h0, 1, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 16'd1, 4'h0, 2, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd1, 4'h0, 2, 64'h0, 1'b0, 1'b0, 1'b0});
        // retrigger reload 200 -> 10
        tbl.push_back('{1'b1, 4'h1, 16'd200, 4'h1, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd200, 4'h1, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 16'd10, 4'h1, 0, 64'hFFC0_0000_0000_0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd10, 4'h1, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        // no-retrigger drop mid-pulse
        tbl.push_back('{1'b1, 4'h8, 16'd200, 4'h0, 3, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd200, 4'h0, 3, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h8, 16'd200, 4'h0, 3, ONES, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 16'd200, 4'h0, 3, 64'hFF00_0000_0000_0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd200, 4'h0, 3, 64'h0, 1'b0, 1'b0, 1'b0});
        // len=0 drop, enable abort, edges ignored while disabled
        tbl.push_back('{1'b1, 4'h1, 16'd0, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 16'd0, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 16'd100, 4'h0, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 16'd100, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd100, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h1, 16'd0, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 16'd50, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h1, 16'd50, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd50, 4'h0, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        // edge in the done cycle, retrig=0: drop and done together
        tbl.push_back('{1'b1, 4'h2, 16'd150, 4'h0, 1, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd150, 4'h0, 1, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 16'd150, 4'h0, 1, 64'hFFFF_FC00_0000_0000, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 16'd150, 4'h0, 1, 64'h0, 1'b0, 1'b0, 1'b0});
        // edge in the done cycle, retrig=1: reload, no done
        tbl.push_back('{1'b1, 4'h4, 16'd150, 4'h4, 2, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd150, 4'h4, 2, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 16'd100, 4'h4, 2, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd100, 4'h4, 2, 64'hFFFF_FFFF_F000_0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd100, 4'h4, 2, 64'h0, 1'b0, 1'b0, 1'b0});
        // retrig with len=0 does not abort
        tbl.push_back('{1'b1, 4'h1, 16'd150, 4'h1, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 16'd150, 4'h1, 0, ONES, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 16'd0, 4'h1, 0, 64'hFFFF_FC00_0000_0000, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 16'd0, 4'h1, 0, 64'h0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        tag = "reset";
        check("reset outputs", {o_pulse, o_busy, o_done, o_drop}, '0);
        @(negedge clk) rstb = 1'b1;
        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].p, {4{tbl[i].len}}, tbl[i].rt);
            push(tbl[i].ch, tbl[i].word, tbl[i].busy, tbl[i].done, tbl[i].drop);
            tag = $sformatf("row%0d", i);
            settle();
        end
        tag = "async_rst";
        apply(1'b1, 4'h1, {4{16'd200}}, 4'h0);
        push(0, ONES, 1'b1, 1'b0, 1'b0);
        settle();
        #2 rstb = 1'b0;
        #1 check("async reset outputs", {o_pulse, o_busy, o_done, o_drop}, '0);
        i_len = {4{16'd64}};
        @(negedge clk) rstb = 1'b1;
        tag = "held_at_release";
        push(0, ONES, 1'b1, 1'b1, 1'b0);
        settle();
        apply(1'b1, 4'h1, {4{16'd64}}, 4'h0);
        push(0, 64'h0, 1'b0, 1'b0, 1'b0);
        settle();
        apply(1'b1, 4'h0, {4{16'd64}}, 4'h0);
        push(0, 64'h0, 1'b0, 1'b0, 1'b0);
        settle();
        tag = "all_ch";
        apply(1'b1, 4'hF, {16'd1, 16'd100, 16'd64, 16'd10}, 4'h0);
        push(0, 64'hFFC0_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        push(1, ONES, 1'b1, 1'b1, 1'b0);
        push(2, ONES, 1'b1, 1'b0, 1'b0);
        push(3, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        settle();
        apply(1'b1, 4'h0, {16'd1, 16'd100, 16'd64, 16'd10}, 4'h0);
        push(0, 64'h0, 1'b0, 1'b0, 1'b0);
        push(1, 64'h0, 1'b0, 1'b0, 1'b0);
        push(2, 64'hFFFF_FFFF_F000_0000, 1'b1, 1'b1, 1'b0);
        push(3, 64'h0, 1'b0, 1'b0, 1'b0);
        settle();
        apply(1'b1, 4'h0, {16'd1, 16'd100, 16'd64, 16'd10}, 4'h0);
        push(2, 64'h0, 1'b0, 1'b0, 1'b0);
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
